// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: execute-stage sequencer for load-use bubbles, memory-busy freezes,
// and registered PC redirects followed by a fixed-length wrong-path flush.
module ex_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_rd_we,
  input  logic             ex_is_load,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             redirect_valid,
  output logic [31:0]      redirect_addr,
  output logic             misalign_err,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);
  typedef enum logic {RUN, REDIRECT} state_t;
  state_t     state, state_nxt;
  logic [2:0] fcnt, fcnt_nxt;
  logic       hazard, capture, load_use;
  always_comb begin
    hazard   = id_valid & ex_valid & ex_is_load & ex_rd_we & (ex_rd_addr != 5'd0) &
               ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));
    capture  = (state == RUN) & ex_valid & ex_taken & ~mem_busy;
    load_use = (state == RUN) & ~mem_busy & ~capture & hazard;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      fcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  // the flush countdown freezes while memory is busy, stretching the window
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    if (capture) begin
      state_nxt = REDIRECT;
      fcnt_nxt  = 3'(FLUSH_CYCLES - 1);
    end else if (state == REDIRECT && !mem_busy) begin
      if (fcnt == 3'd0) state_nxt = RUN;
      else fcnt_nxt = fcnt - 3'd1;
    end
  end
  // gated by rst_n so control outputs are quiet for the whole reset period
  always_comb begin
    stall_if = rst_n & (mem_busy | load_use);
    stall_id = rst_n & (mem_busy | load_use);
    stall_ex = rst_n & mem_busy;
    flush_id = rst_n & (state == REDIRECT) & ~mem_busy;
    flush_ex = rst_n & (((state == REDIRECT) & ~mem_busy) | load_use);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      misalign_err   <= 1'b0;
      redirect_addr  <= 32'd0;
      load_stall_cnt <= '0;
      redirect_cnt   <= '0;
    end else begin
      redirect_valid <= capture;
      misalign_err   <= capture & (ex_target[1:0] != 2'b00);
      if (capture) redirect_addr <= {ex_target[31:2], 2'b00};
      if (load_use && !(&load_stall_cnt)) load_stall_cnt <= load_stall_cnt + 1'b1;
      if (capture && !(&redirect_cnt)) redirect_cnt <= redirect_cnt + 1'b1;
    end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: table-driven load-use/busy vectors plus redirect sequences,
// with a queue of expected redirect pulses checked by a monitor.
module tb_ex_hazard_ctrl;
  localparam int CW = 8;
  logic clk = 1'b0, rst_n;
  logic id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_rd_we, ex_is_load, ex_taken, mem_busy;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic [31:0] ex_target, redirect_addr;
  logic stall_if, stall_id, stall_ex, flush_id, flush_ex, redirect_valid, misalign_err;
  logic [CW-1:0] load_stall_cnt, redirect_cnt;
  logic [6:0] outs;
  logic [4:0] ctl;
  int n = 0, errs = 0, exp_lsc = 0, exp_rc = 0;

  typedef struct {
    logic       idv;
    logic [4:0] rs1, rs2;
    logic       u1, u2, exv;
    logic [4:0] rd;
    logic       we, ld, busy;
    logic [3:0] exp;
  } vec_t;
  typedef struct {
    logic [31:0] addr;
    logic        mis;
  } rd_t;
  vec_t v[10];
  rd_t  exp_q[$];
  rd_t  r;

  ex_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load),
    .ex_taken(ex_taken), .ex_target(ex_target), .mem_busy(mem_busy), .stall_if(stall_if),
    .stall_id(stall_id), .stall_ex(stall_ex), .flush_id(flush_id), .flush_ex(flush_ex),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .misalign_err(misalign_err),
    .load_stall_cnt(load_stall_cnt), .redirect_cnt(redirect_cnt)
  );

  always #5 clk = ~clk;
  assign outs = {stall_if, stall_id, stall_ex, flush_id, flush_ex, redirect_valid, misalign_err};
  assign ctl  = {stall_if, stall_id, stall_ex, flush_id, flush_ex};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    {id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_rd_we, ex_is_load, ex_taken, mem_busy} = '0;
    {id_rs1_addr, id_rs2_addr, ex_rd_addr} = '0;
    ex_target = '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t x);
    id_valid = x.idv; id_rs1_addr = x.rs1; id_rs2_addr = x.rs2;
    id_uses_rs1 = x.u1; id_uses_rs2 = x.u2; ex_valid = x.exv;
    ex_rd_addr = x.rd; ex_rd_we = x.we; ex_is_load = x.ld; mem_busy = x.busy;
    ex_taken = 1'b0;
  endtask

  task automatic take(input logic [31:0] tgt);
    ex_valid = 1'b1; ex_taken = 1'b1; ex_target = tgt;
    exp_q.push_back('{{tgt[31:2], 2'b00}, tgt[1:0] != 2'b00});
    exp_rc++;
  endtask

  // every redirect pulse must match the oldest expected one; stray pulses fail
  always @(negedge clk) if (rst_n) begin
    if (redirect_valid) begin
      if (exp_q.size() == 0) begin
        n++; errs++;
        $display("FAIL redirect_unexpected: got pulse addr %0h, expected none", redirect_addr);
      end else begin
        r = exp_q.pop_front();
        chk("redirect_addr", redirect_addr, r.addr);
        chk("misalign_err", misalign_err, r.mis);
      end
    end else if (misalign_err) begin
      n++; errs++;
      $display("FAIL misalign_stray: got 1, expected 0");
    end
  end

  initial begin
    //      idv rs1    rs2    u1 u2 exv rd     we ld busy  {sif,sid,sex,fex}
    v[0] = '{1, 5'd3,  5'd5,  1, 1, 1, 5'd5,  1, 1, 0, 4'b1101};
    v[1] = '{1, 5'd3,  5'd0,  1, 1, 1, 5'd0,  1, 1, 0, 4'b0000};
    v[2] = '{1, 5'd3,  5'd5,  1, 0, 1, 5'd5,  1, 1, 0, 4'b0000};
    v[3] = '{1, 5'd7,  5'd0,  1, 0, 1, 5'd7,  1, 1, 0, 4'b1101};
    v[4] = '{1, 5'd3,  5'd5,  1, 1, 1, 5'd5,  1, 0, 0, 4'b0000};
    v[5] = '{1, 5'd3,  5'd5,  1, 1, 1, 5'd5,  0, 1, 0, 4'b0000};
    v[6] = '{0, 5'd3,  5'd5,  1, 1, 1, 5'd5,  1, 1, 0, 4'b0000};
    v[7] = '{1, 5'd3,  5'd5,  1, 1, 1, 5'd5,  1, 1, 1, 4'b1110};
    v[8] = '{0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 1, 4'b1110};
    v[9] = '{1, 5'd3,  5'd5,  1, 1, 0, 5'd5,  1, 1, 0, 4'b0000};
    rst_n = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      {id_valid, id_uses_rs1, id_uses_rs2, ex_valid, ex_rd_we, ex_is_load, ex_taken, mem_busy} = 8'($urandom);
      {id_rs1_addr, id_rs2_addr, ex_rd_addr} = 15'($urandom);
      ex_target = $urandom;
      @(negedge clk);
      chk("reset_outs", 32'(outs), 0);
      chk("reset_addr", redirect_addr, 0);
      chk("reset_cnts", {load_stall_cnt, redirect_cnt}, 0);
      nxt();
    end
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_outs", 32'(outs), 0);
    nxt();
    for (int i = 0; i < 10; i++) begin
      apply(v[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(ctl), {v[i].exp[3:1], 1'b0, v[i].exp[0]});
      if (v[i].exp[0] && !v[i].busy) exp_lsc++;
      nxt();
    end
    idle();
    chk("load_stall_cnt", 32'(load_stall_cnt), exp_lsc);
    take(32'h0000_1040);
    @(negedge clk);
    chk("capture_cycle", 32'(ctl), 0);
    for (int i = 0; i < 2; i++) begin
      nxt();
      ex_target = 32'h0000_5554;
      @(negedge clk);
      chk("flush_a", 32'(ctl), 5'b00011);
    end
    nxt();
    idle();
    @(negedge clk);
    chk("flush_a_end", 32'(ctl), 0);
    nxt();
    chk("redirect_cnt_a", 32'(redirect_cnt), exp_rc);
    chk("redirect_addr_hold", redirect_addr, 32'h0000_1040);
    take(32'h0000_2002);
    nxt();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_b", 32'(ctl), i < 2 ? 5'b00011 : 5'b00000);
      nxt();
    end
    ex_valid = 1'b1; ex_taken = 1'b1; ex_target = 32'h0000_3000; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_taken", 32'(ctl), 5'b11100);
      nxt();
    end
    mem_busy = 1'b0;
    take(32'h0000_3000);
    @(negedge clk);
    chk("busy_release", 32'(ctl), 0);
    nxt();
    for (int i = 0; i < 5; i++) begin
      idle();
      mem_busy = (i < 2);
      @(negedge clk);
      chk("busy_flush", 32'(ctl), i < 2 ? 5'b11100 : (i < 4 ? 5'b00011 : 5'b00000));
      nxt();
    end
    chk("redirect_cnt_c", 32'(redirect_cnt), exp_rc);
    take(32'h0000_4000);
    nxt();
    idle();
    @(negedge clk);
    chk("flush_d", 32'(ctl), 5'b00011);
    nxt();
    rst_n = 1'b0;
    #1;
    chk("abort_outs", 32'(outs), 0);
    chk("abort_addr", redirect_addr, 0);
    chk("abort_cnts", {load_stall_cnt, redirect_cnt}, 0);
    exp_lsc = 0;
    exp_rc = 0;
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release", 32'(outs), 0);
    nxt();
    apply(v[0]);
    repeat (2 ** CW - 1) @(posedge clk);
    #1;
    chk("lsc_full", 32'(load_stall_cnt), 2 ** CW - 1);
    repeat (4) @(posedge clk);
    #1;
    chk("lsc_saturated", 32'(load_stall_cnt), 2 ** CW - 1);
    idle();
    nxt();
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
